// File: rtl/cond_status_unit.sv
// Condition/status unit: architectural {Z,C,N,V} flags, ID-stage condition
// check with optional EXE->ID flag bypass, and a saturating squash counter.
module cond_status_unit #(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       status_in,
  input  logic             s_update,
  input  logic             exe_valid,
  input  logic [3:0]       cond,
  input  logic             id_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       status_reg,
  output logic             c_out,
  output logic             cond_ok,
  output logic             exe_cond_pass,
  output logic [CNT_W-1:0] skip_cnt
);

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       r_status;
  logic             r_pass;
  logic [CNT_W-1:0] r_skip;

  logic             w_flag_wr;
  logic [3:0]       w_flags;
  logic             w_z, w_c, w_n, w_v;
  logic             w_cond_ok;
  logic             w_advance;
  logic             w_skip_inc;

  assign w_flag_wr = exe_valid & s_update;

  // Flags being written this cycle are visible to the ID check only when bypassing.
  assign w_flags = ((BYPASS != 0) && w_flag_wr) ? status_in : r_status;

  assign w_z = w_flags[3];
  assign w_c = w_flags[2];
  assign w_n = w_flags[1];
  assign w_v = w_flags[0];

  always_comb begin
    w_cond_ok = 1'b0;
    case (cond)
      COND_EQ: w_cond_ok = w_z;
      COND_NE: w_cond_ok = ~w_z;
      COND_CS: w_cond_ok = w_c;
      COND_CC: w_cond_ok = ~w_c;
      COND_MI: w_cond_ok = w_n;
      COND_PL: w_cond_ok = ~w_n;
      COND_VS: w_cond_ok = w_v;
      COND_VC: w_cond_ok = ~w_v;
      COND_HI: w_cond_ok = w_c & ~w_z;
      COND_LS: w_cond_ok = ~w_c | w_z;
      COND_GE: w_cond_ok = (w_n == w_v);
      COND_LT: w_cond_ok = (w_n != w_v);
      COND_GT: w_cond_ok = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ok = w_z | (w_n != w_v);
      COND_AL: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  assign w_advance  = ~flush & ~stall;
  assign w_skip_inc = w_advance & id_valid & ~w_cond_ok;

  // Flag write is independent of stall/flush: it belongs to the EXE instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= 4'b0000;
    end else if (w_flag_wr) begin
      r_status <= status_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pass <= 1'b0;
    end else if (flush) begin
      r_pass <= 1'b0;
    end else if (!stall) begin
      r_pass <= id_valid & w_cond_ok;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skip <= '0;
    end else if (w_skip_inc && (r_skip != CNT_MAX)) begin
      r_skip <= r_skip + CNT_ONE;
    end
  end

  assign status_reg    = r_status;
  assign c_out         = r_status[2];
  assign cond_ok       = w_cond_ok;
  assign exe_cond_pass = r_pass;
  assign skip_cnt      = r_skip;

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed bench for cond_status_unit: one bypassing 4-bit-counter instance
// and one non-bypassing 16-bit-counter instance driven by the same inputs.
module tb_cond_status_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  status_in;
  logic        s_update;
  logic        exe_valid;
  logic [3:0]  cond;
  logic        id_valid;
  logic        stall;
  logic        flush;

  logic [3:0]  status_reg_a, status_reg_b;
  logic        c_out_a, c_out_b;
  logic        cond_ok_a, cond_ok_b;
  logic        pass_a, pass_b;
  logic [3:0]  skip_a;
  logic [15:0] skip_b;

  int errors = 0;
  int checks = 0;

  cond_status_unit #(.BYPASS(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .status_in(status_in), .s_update(s_update),
    .exe_valid(exe_valid), .cond(cond), .id_valid(id_valid), .stall(stall),
    .flush(flush), .status_reg(status_reg_a), .c_out(c_out_a),
    .cond_ok(cond_ok_a), .exe_cond_pass(pass_a), .skip_cnt(skip_a)
  );

  cond_status_unit #(.BYPASS(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .status_in(status_in), .s_update(s_update),
    .exe_valid(exe_valid), .cond(cond), .id_valid(id_valid), .stall(stall),
    .flush(flush), .status_reg(status_reg_b), .c_out(c_out_b),
    .cond_ok(cond_ok_b), .exe_cond_pass(pass_b), .skip_cnt(skip_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cc;
    logic       exp_ok;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference of the condition table.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic z, cy, n, v;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    if (c[3] == 1'b0) begin
      logic bitv;
      case (c[2:1])
        2'd0: bitv = z;
        2'd1: bitv = cy;
        2'd2: bitv = n;
        default: bitv = v;
      endcase
      return c[0] ? ~bitv : bitv;
    end
    case (c[2:1])
      2'd0: return c[0] ? (~cy | z) : (cy & ~z);
      2'd1: return c[0] ? (n ^ v) : ~(n ^ v);
      default: return c[0] ? (z | (n ^ v)) : (~z & ~(n ^ v));
    endcase
  endfunction

  task automatic load_flags(input logic [3:0] f);
    exe_valid = 1'b1; s_update = 1'b1; status_in = f; id_valid = 1'b0;
    step();
    exe_valid = 1'b0; s_update = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0110, 4'b1100, 1'b0};
    vecs[1]  = '{4'b0111, 4'b1010, 1'b1};
    vecs[2]  = '{4'b0100, 4'b1000, 1'b1};
    vecs[3]  = '{4'b1000, 4'b0000, 1'b1};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0001, 1'b1};
    vecs[6]  = '{4'b0010, 4'b0100, 1'b1};
    vecs[7]  = '{4'b0001, 4'b0110, 1'b1};
    vecs[8]  = '{4'b0001, 4'b1011, 1'b1};
    vecs[9]  = '{4'b1100, 4'b1001, 1'b1};
    vecs[10] = '{4'b1100, 4'b1000, 1'b0};
    vecs[11] = '{4'b1000, 4'b1101, 1'b1};
    vecs[12] = '{4'b0000, 4'b1110, 1'b1};
    vecs[13] = '{4'b1111, 4'b1111, 1'b0};
    vecs[14] = '{4'b0100, 4'b0011, 1'b0};
    vecs[15] = '{4'b0011, 4'b0101, 1'b0};

    rst = 1'b1; status_in = 4'h0; s_update = 1'b0; exe_valid = 1'b0;
    cond = 4'h0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("rst_status", status_reg_a, 4'h0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_skip", skip_a, 4'h0);
    check("rst_eq_fails", cond_ok_a, 1'b0);
    step();
    step();
    rst = 1'b1;

    // Same-cycle flag write and check.
    exe_valid = 1'b1; s_update = 1'b1; status_in = 4'b1000; cond = 4'b0000; id_valid = 1'b1;
    #1;
    check("byp_ok_bypass1", cond_ok_a, 1'b1);
    check("byp_ok_bypass0", cond_ok_b, 1'b0);
    check("byp_status_pre", status_reg_a, 4'h0);
    step();
    exe_valid = 1'b0; s_update = 1'b0; id_valid = 1'b0;
    check("byp_status_post", status_reg_a, 4'b1000);
    check("byp_status_post_b", status_reg_b, 4'b1000);
    check("byp_pass_a", pass_a, 1'b1);
    check("byp_pass_b", pass_b, 1'b0);
    check("byp_skip_a", skip_a, 4'd0);
    check("byp_skip_b", skip_b, 16'd1);

    // Hand-computed spot vectors.
    for (int i = 0; i < 16; i++) begin
      load_flags(vecs[i].flags);
      cond = vecs[i].cc;
      #1;
      check($sformatf("vec%0d_status", i), status_reg_a, vecs[i].flags);
      check($sformatf("vec%0d_cout", i), c_out_a, vecs[i].flags[2]);
      check($sformatf("vec%0d_ok_a", i), cond_ok_a, vecs[i].exp_ok);
      check($sformatf("vec%0d_ok_b", i), cond_ok_b, vecs[i].exp_ok);
    end

    // Full 16x16 sweep without a concurrent flag write.
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        check($sformatf("sweep_f%0h_c%0h", f, c), cond_ok_a, ref_cond(4'(f), 4'(c)));
      end
    end
    check("sweep_skip_held", skip_a, 4'd0);

    // Stall holds, flush beats stall.
    load_flags(4'b0000);
    cond = 4'b1110; id_valid = 1'b1;
    step();
    check("sf_pass_set", pass_a, 1'b1);
    cond = 4'b0000; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("sf_stall%0d_pass", k), pass_a, 1'b1);
      check($sformatf("sf_stall%0d_skip", k), skip_a, 4'd0);
    end
    flush = 1'b1;
    step();
    check("sf_flush_pass", pass_a, 1'b0);
    check("sf_flush_skip", skip_a, 4'd0);
    stall = 1'b0; flush = 1'b0; cond = 4'b1110;
    step();
    check("sf_resume_pass", pass_a, 1'b1);
    id_valid = 1'b0; cond = 4'b0000;
    step();
    check("idv0_pass", pass_a, 1'b0);
    check("idv0_skip", skip_a, 4'd0);

    // Saturation of the 4-bit counter.
    id_valid = 1'b1; cond = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("sat%0d", k), skip_a, (k + 1 > 15) ? 4'd15 : 4'(k + 1));
    end
    check("sat_wide_b", skip_b, 16'd21);
    id_valid = 1'b0;

    // Reset mid-operation discards a pending flag write.
    load_flags(4'b1111);
    check("mid_status_pre", status_reg_a, 4'b1111);
    exe_valid = 1'b1; s_update = 1'b1; status_in = 4'b0101;
    id_valid = 1'b1; cond = 4'b1110;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_status", status_reg_a, 4'h0);
    check("mid_rst_pass", pass_a, 1'b0);
    check("mid_rst_skip", skip_a, 4'd0);
    check("mid_rst_skip_b", skip_b, 16'd0);
    step();
    check("mid_rst_hold_status", status_reg_a, 4'h0);
    check("mid_rst_hold_pass", pass_a, 1'b0);
    rst = 1'b1;
    step();
    check("post_rst_status", status_reg_a, 4'b0101);
    check("post_rst_pass", pass_a, 1'b1);
    check("post_rst_status_b", status_reg_b, 4'b0101);
    exe_valid = 1'b0; s_update = 1'b0; id_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
